// File: rtl/dmem_io_responder_if.sv
// Data-memory port of the core plus the byte-stream handshake to the external consumer.
interface dmem_io_responder_if #(
    parameter int unsigned FIFO_W = 8
);
    logic              MemWrite;
    logic [31:0]       DataAdr;
    logic [31:0]       WriteData;
    logic [31:0]       ReadData;
    logic [FIFO_W-1:0] TxData;
    logic              TxValid;
    logic              TxReady;

    // master: core driving the bus and the consumer draining the stream
    modport master (
        output MemWrite, DataAdr, WriteData, TxReady,
        input  ReadData, TxData, TxValid
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, TxReady,
        output ReadData, TxData, TxValid
    );
endinterface

// File: rtl/dmem_io_responder.sv
// Data-memory responder: word RAM, free-running cycle counter and a byte output FIFO,
// with combinational reads and clocked writes.
module dmem_io_responder #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_io_responder_if.slave   bus
);
    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [1:0] SEL_CYCLE  = 2'd0;
    localparam logic [1:0] SEL_TXFIFO = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;

    logic [31:0]       ram_q  [RAM_WORDS];
    logic [FIFO_W-1:0] fifo_q [FIFO_DEPTH];

    logic [31:0]      cycle_q, cycle_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic              in_ram, in_io;
    logic [1:0]        io_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              empty, full;
    logic              push, pop, push_ok, status_wr;
    logic [31:0]       status;
    logic [31:0]       read_data;
    logic              unused_adr;

    assign in_ram  = (bus.DataAdr[31:16] == 16'h0000);
    assign in_io   = (bus.DataAdr[31:16] == 16'hFFFF);
    assign io_sel  = bus.DataAdr[3:2];
    assign ram_idx = bus.DataAdr[RAM_AW+1:2];
    assign unused_adr = ^{bus.DataAdr[15:RAM_AW+2], bus.DataAdr[1:0]};

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = !empty && bus.TxReady;
    assign push      = bus.MemWrite && in_io && (io_sel == SEL_TXFIFO);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok   = push && (!full || pop);
    assign status_wr = bus.MemWrite && in_io && (io_sel == SEL_STATUS);

    assign status = {16'h0000, 8'(count_q), 5'b00000, ovf_q, full, empty};

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        rptr_d  = pop     ? rptr_q + PTR_W'(1) : rptr_q;
        wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        ovf_d   = ovf_q;
        if (status_wr) begin
            ovf_d = 1'b0;
        end else if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        read_data = '0;
        if (in_ram) begin
            read_data = ram_q[ram_idx];
        end else if (in_io) begin
            case (io_sel)
                SEL_CYCLE:  read_data = cycle_q;
                SEL_STATUS: read_data = status;
                default:    read_data = '0;
            endcase
        end
    end

    assign bus.ReadData = read_data;
    assign bus.TxData   = fifo_q[rptr_q];
    assign bus.TxValid  = !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage arrays keep their contents across reset.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && in_ram) begin
            ram_q[ram_idx] <= bus.WriteData;
        end
        if (push_ok) begin
            fifo_q[wptr_q] <= bus.WriteData[FIFO_W-1:0];
        end
    end
endmodule

// File: tb/tb_dmem_io_responder.sv
// Bench for dmem_io_responder: directed vector table, randomized traffic against a
// queue-based reference model, and mid-operation reset sequences.
module tb_dmem_io_responder;
    localparam int unsigned RAM_WORDS  = 64;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_W     = 8;

    logic clk;
    logic reset;

    dmem_io_responder_if #(.FIFO_W(FIFO_W)) bus ();

    dmem_io_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .FIFO_W    (FIFO_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;

    // Reference model
    logic [31:0] m_cycle;
    logic [7:0]  m_fifo[$];
    logic        m_ovf;
    logic [31:0] m_ram  [RAM_WORDS];
    bit          m_known[RAM_WORDS];

    // Samples and model expectations of the most recent step
    logic [31:0] s_rd;
    logic        s_v;
    logic [7:0]  s_d;
    logic [31:0] e_rd;
    bit          e_known;
    logic        e_v;
    logic [7:0]  e_d;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        rdy;
        bit          chk_rd;
        logic [31:0] rd;
        logic        valid;
        logic [7:0]  txd;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int unsigned word_of(input logic [31:0] adr);
        return (int'(adr) >>> 2) % RAM_WORDS;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] adr);
        int unsigned sel;
        sel = (adr >> 2) & 32'd3;
        if (adr[31:16] == 16'h0000) return m_ram[(adr >> 2) % RAM_WORDS];
        if (adr[31:16] != 16'hFFFF) return 32'h0;
        if (sel == 0) return m_cycle;
        if (sel == 2) return {16'h0000, 8'(m_fifo.size()), 5'b00000, m_ovf,
                              m_fifo.size() == FIFO_DEPTH, m_fifo.size() == 0};
        return 32'h0;
    endfunction

    function automatic bit model_known(input logic [31:0] adr);
        if (adr[31:16] == 16'h0000) return m_known[(adr >> 2) % RAM_WORDS];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_cycle = '0;
        m_fifo.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                              input logic rdy);
        int unsigned sel;
        bit is_io;
        sel   = (adr >> 2) & 32'd3;
        is_io = (adr[31:16] == 16'hFFFF);
        if (rdy && m_fifo.size() != 0) void'(m_fifo.pop_front());
        if (we && is_io && sel == 1) begin
            if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(wd[7:0]);
            else m_ovf = 1'b1;
        end
        if (we && is_io && sel == 2) m_ovf = 1'b0;
        if (we && adr[31:16] == 16'h0000) begin
            m_ram[(adr >> 2) % RAM_WORDS]   = wd;
            m_known[(adr >> 2) % RAM_WORDS] = 1'b1;
        end
        m_cycle = m_cycle + 32'd1;
    endtask

    // Entered at posedge+1: drive, sample at the falling edge, advance one clock.
    task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic rdy);
        bus.MemWrite  = we;
        bus.DataAdr   = adr;
        bus.WriteData = wd;
        bus.TxReady   = rdy;
        #4;
        s_rd    = bus.ReadData;
        s_v     = bus.TxValid;
        s_d     = bus.TxData;
        e_rd    = model_read(adr);
        e_known = model_known(adr);
        e_v     = (m_fifo.size() != 0);
        e_d     = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
        @(posedge clk);
        model_edge(we, adr, wd, rdy);
        #1;
    endtask

    task automatic model_compare(input string tag);
        if (e_known) check({tag, " rd"}, s_rd, e_rd);
        check({tag, " valid"}, {31'b0, s_v}, {31'b0, e_v});
        if (e_v) check({tag, " txd"}, {24'b0, s_d}, {24'b0, e_d});
    endtask

    // Reset asserted between edges; outputs must react before the next edge.
    task automatic pulse_reset(input string tag);
        bus.MemWrite = 1'b0;
        bus.TxReady  = 1'b0;
        bus.DataAdr  = 32'hFFFF_0000;
        reset = 1'b1;
        #1;
        check({tag, " valid_in_reset"}, {31'b0, bus.TxValid}, 32'h0);
        check({tag, " cycle_in_reset"}, bus.ReadData, 32'h0);
        bus.DataAdr = 32'hFFFF_0008;
        #1;
        check({tag, " status_in_reset"}, bus.ReadData, 32'h0000_0001);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        model_edge(1'b0, bus.DataAdr, 32'h0, 1'b0);
        #1;
    endtask

    task automatic add(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic rdy, input bit chk_rd, input logic [31:0] rd,
                       input logic valid, input logic [7:0] txd);
        vec_t v;
        v.we = we; v.adr = adr; v.wd = wd; v.rdy = rdy;
        v.chk_rd = chk_rd; v.rd = rd; v.valid = valid; v.txd = txd;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] adr;
        logic        we;
        logic        rdy;
        int unsigned kind;
        int unsigned rdy_pct;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;
        bus.TxReady   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset("rst0");

        // Cycle counter: one clock has already elapsed since release.
        for (int unsigned i = 0; i < 10; i++)
            add(0, 32'hFFFF_0000, 0, 0, 1, 32'(i + 1), 0, 0);
        add(0, 32'hFFFF_0000, 0,              0, 1, 32'd11, 0, 0);
        add(1, 32'hFFFF_0000, 32'h0000_1234,  0, 1, 32'd12, 0, 0);
        add(0, 32'hFFFF_0000, 0,              0, 1, 32'd13, 0, 0);
        // RAM, read-during-write, low bits, aliasing, unmapped
        add(1, 32'h0000_0010, 32'h1111_1111,  0, 0, 0,             0, 0);
        add(1, 32'h0000_0010, 32'hDEAD_BEEF,  0, 1, 32'h1111_1111, 0, 0);
        add(0, 32'h0000_0010, 0,              0, 1, 32'hDEAD_BEEF, 0, 0);
        add(0, 32'h0000_0013, 0,              0, 1, 32'hDEAD_BEEF, 0, 0);
        add(0, 32'h0040_0000, 0,              0, 1, 0,             0, 0);
        add(1, 32'h0040_0000, 32'hFFFF_FFFF,  0, 1, 0,             0, 0);
        add(0, 32'h0000_0110, 0,              0, 1, 32'hDEAD_BEEF, 0, 0);
        // FIFO fill and overflow
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h001, 0, 0);
        add(1, 32'hFFFF_0004, 32'h41,         0, 1, 0,       0, 0);
        add(1, 32'hFFFF_0004, 32'h42,         0, 1, 0,       1, 8'h41);
        add(1, 32'hFFFF_0004, 32'h43,         0, 1, 0,       1, 8'h41);
        add(1, 32'hFFFF_0004, 32'h44,         0, 1, 0,       1, 8'h41);
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h402, 1, 8'h41);
        add(1, 32'hFFFF_0004, 32'hAB00_0045,  0, 1, 0,       1, 8'h41);
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h406, 1, 8'h41);
        add(1, 32'hFFFF_0008, 0,              0, 1, 32'h406, 1, 8'h41);
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h402, 1, 8'h41);
        add(1, 32'hFFFF_000C, 32'hFFFF_FFFF,  0, 1, 0,       1, 8'h41);
        add(0, 32'hFFFF_000C, 0,              0, 1, 0,       1, 8'h41);
        // Drain
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h402, 1, 8'h41);
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h300, 1, 8'h42);
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h200, 1, 8'h43);
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h100, 1, 8'h44);
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h001, 0, 0);
        // Full with simultaneous push and pop
        add(1, 32'hFFFF_0004, 32'h61,         0, 1, 0,       0, 0);
        add(1, 32'hFFFF_0004, 32'h62,         0, 1, 0,       1, 8'h61);
        add(1, 32'hFFFF_0004, 32'h63,         0, 1, 0,       1, 8'h61);
        add(1, 32'hFFFF_0004, 32'h64,         0, 1, 0,       1, 8'h61);
        add(1, 32'hFFFF_0004, 32'h55,         1, 1, 0,       1, 8'h61);
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h402, 1, 8'h62);
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h402, 1, 8'h62);
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h300, 1, 8'h63);
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h200, 1, 8'h64);
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h100, 1, 8'h55);
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h001, 0, 0);
        // Push into empty (no bypass), then push with pop at count 1
        add(1, 32'hFFFF_0004, 32'h71,         1, 1, 0,       0, 0);
        add(1, 32'hFFFF_0004, 32'h72,         1, 1, 0,       1, 8'h71);
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h100, 1, 8'h72);
        add(0, 32'hFFFF_0008, 0,              1, 1, 32'h100, 1, 8'h72);
        add(0, 32'hFFFF_0008, 0,              0, 1, 32'h001, 0, 0);

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            step(vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].rdy);
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d rd", i), s_rd, vecs[i].rd);
            check($sformatf("vec%0d valid", i), {31'b0, s_v}, {31'b0, vecs[i].valid});
            if (vecs[i].valid)
                check($sformatf("vec%0d txd", i), {24'b0, s_d}, {24'b0, vecs[i].txd});
        end

        // Randomized traffic; consumer readiness varies in phases to reach full and overflow.
        rdy_pct = 50;
        for (int unsigned n = 0; n < 2000; n++) begin
            if (n % 200 == 0) rdy_pct = $urandom_range(5, 95);
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                adr = $urandom & 32'h0000_FFFF;
            end else if (kind < 9) begin
                adr = 32'hFFFF_0000 | ($urandom & 32'h0000_FFFF);
            end else begin
                adr = (32'($urandom_range(1, 32'hFFFE)) << 16) | ($urandom & 32'h0000_FFFF);
            end
            we  = ($urandom_range(0, 99) < 45);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            step(we, adr, $urandom, rdy);
            model_compare($sformatf("rnd%0d", n));
        end

        // Reset mid-operation with two entries queued and CYCLE near 50.
        step(1, 32'h0000_0020, 32'hCAFE_F00D, 0);
        pulse_reset("rst1");
        step(1, 32'hFFFF_0004, 32'hA1, 0);
        model_compare("mid push1");
        step(1, 32'hFFFF_0004, 32'hA2, 0);
        model_compare("mid push2");
        for (int unsigned n = 0; n < 100 && m_cycle < 50; n++) begin
            step(0, 32'hFFFF_0000, 0, 0);
            model_compare("mid wait");
        end
        check("mid count_before_reset", s_rd, 32'd49);
        check("mid valid_before_reset", {31'b0, s_v}, 32'h1);
        pulse_reset("rst2");
        step(0, 32'hFFFF_0008, 0, 0);
        check("post status", s_rd, 32'h0000_0001);
        check("post valid", {31'b0, s_v}, 32'h0);
        step(0, 32'h0000_0020, 0, 0);
        check("post ram", s_rd, 32'hCAFE_F00D);
        step(0, 32'hFFFF_0000, 0, 0);
        check("post cycle", s_rd, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
